sample_pacer: RTL and testbench
===============================

Name: sample_pacer

Overview:
- Digital stage directly upstream of the two 8-bit R-2R DACs, instantiated inside digital_top.
- Accepts a byte stream: first byte of each frame is channel A, second is channel B. Bytes are packed into 16-bit stereo frames and buffered in a small FIFO.
- Frames are released to o_digital at a programmable sample rate: o_digital[15:8] drives the ua[0] DAC, o_digital[7:0] drives the ua[1] DAC.
- Absorbs bursty host writes and gives the DACs a jitter-free update cadence.

Parameters:
- FIFO_DEPTH, 8: frames buffered; power of two, minimum 2.
- DIV_W, 16: width of the sample-period divider.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-high.
- in_data, input, 8: sample byte from the host.
- in_valid, input, 1: in_data valid.
- in_ready, output, 1: byte accepted when in_valid && in_ready.
- enable, input, 1: playback run/pause.
- div, input, DIV_W: sample period minus one, in clk cycles.
- o_digital, output, 16: {chA, chB} sample to the DACs.
- sample_tick, output, 1: one-cycle pulse on each playback slot.
- underrun, output, 1: one-cycle pulse on a slot that found the FIFO empty.
- fifo_level, output, $clog2(FIFO_DEPTH)+1: frames currently stored.

Behaviour:
- Reset (rst high at a clk edge):
  - o_digital=16'h8080 (midscale on both channels); sample_tick=0; underrun=0; fifo_level=0.
  - FIFO emptied; assembler in state HI; divider counter loaded with div.
  - Reset mid-frame discards a held half-frame.
- in_ready = (fifo_level != FIFO_DEPTH). It is independent of assembler state.
- Byte assembler FSM:
  - HI: on accept, hold_reg <= in_data, go to LO.
  - LO: on accept, push {hold_reg, in_data} into the FIFO, go to HI.
  - No accept means no state change; no timeout.
- Divider:
  - While enable=0: counter <= div, no ticks, o_digital holds.
  - While enable=1: counter decrements. On counter==0 it reloads div and a slot fires in the same cycle.
  - Slot period is therefore div+1 cycles; div=0 gives a slot every cycle.
  - A div change takes effect at the next reload.
- Slot handling:
  - sample_tick=1 in the cycle after the slot edge (registered).
  - FIFO non-empty at the slot: pop; o_digital <= head frame, registered, visible together with sample_tick.
  - FIFO empty at the slot: underrun=1, o_digital holds its previous value.
- Simultaneous push and slot:
  - FIFO empty: the slot reports underrun. There is no bypass, and the pushed frame is stored (level becomes 1).
  - FIFO non-empty: pop and push both happen; level is unchanged.
- Latency: a frame pushed at cycle N can appear on o_digital at the earliest on the slot at cycle N+1, output at N+2.
- fifo_level changes by at most ±1 per cycle. It is never above FIFO_DEPTH, and never pops below 0.
- Pointer wrap-around uses modulo-FIFO_DEPTH pointers with an extra wrap bit for full/empty.

Optional Feature:
- Macro: SAMPLE_PACER_UNDERRUN_CNT_EN.
- With the macro defined:
  - Extra output underrun_cnt[7:0], reset 0.
  - Increments on each underrun pulse and saturates at 8'hFF.
  - Cleared synchronously when enable rises 0→1.
- Without the macro: port and logic absent; underrun pulse unchanged.

Decomposition:
- Package audio_pkg holds:
  - typedef sample_t (8-bit), typedef frame_t (struct of chA and chB sample_t).
  - constant MIDSCALE=8'h80.
  - enum asm_state_t {HI, LO}.
- One sub-module, sample_fifo: synchronous FIFO with push/pop, full/empty and level, parameterised by FIFO_DEPTH. The pacer instantiates it.
- Assembler and divider stay inline.

Test Plan:
- Reset check: assert rst for 3 cycles with enable=1 -> o_digital=16'h8080, fifo_level=0, in_ready=1, no sample_tick.
- Pacing: div=3, bytes 11,22,33,44 pushed, then enable=1 -> o_digital=16'h1122 then 16'h3344, sample_tick spaced exactly 4 cycles apart.
- Underrun: after the FIFO drains with div=3 -> underrun pulses every 4 cycles and o_digital stays 16'h3344. With SAMPLE_PACER_UNDERRUN_CNT_EN, underrun_cnt counts 1,2,3…
- Full backpressure: enable=0, push 2*FIFO_DEPTH bytes -> fifo_level=FIFO_DEPTH, in_ready=0. Further bytes are not accepted, and ordering is preserved on later playback.
- Half-frame reset: push byte AA, assert rst, then push BB,CC and play -> output 16'hBBCC; AA never appears.
- Simultaneous events: div=0, enable=1, FIFO empty, complete a frame (0x5A,0xA5) on a slot cycle -> underrun on that slot, o_digital=16'h5AA5 on the next slot.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and constants for the DAC sample path.
package audio_pkg;

  typedef logic [7:0] sample_t;

  // ch_a is the first byte of a frame and occupies the upper half of the
  // packed 16-bit value, so a frame_t maps directly onto o_digital.
  typedef struct packed {
    sample_t ch_a;
    sample_t ch_b;
  } frame_t;

  localparam sample_t MIDSCALE = 8'h80;

  // Byte assembler: HI waits for channel A, LO waits for channel B.
  typedef enum logic {
    HI = 1'b0,
    LO = 1'b1
  } asm_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous frame FIFO. Pointers carry one wrap bit above the address so
// that full and empty are told apart. A push while full and a pop while empty
// are ignored internally. Push and pop in the same cycle both take effect.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_i,
  input  frame_t                      wdata_i,
  input  logic                        pop_i,
  output frame_t                      rdata_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = FIFO_DEPTH[AW:0];

  frame_t      mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic        do_push;
  logic        do_pop;

  assign level_o = wr_q - rd_q;
  assign full_o  = (level_o == FULL_LVL);
  assign empty_o = (wr_q == rd_q);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer advance for accepted operations.
  always_comb begin
    wr_d = wr_q + {{AW{1'b0}}, do_push};
    rd_d = rd_q + {{AW{1'b0}}, do_pop};
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/sample_pacer.sv
// Sample pacer: packs host bytes into stereo frames, buffers them and
// releases one frame per programmable slot to the two R-2R DACs.
// Optional feature macro: SAMPLE_PACER_UNDERRUN_CNT_EN adds a saturating
// underrun counter output (underrun_cnt), cleared when enable rises.
//
// Handshake: a byte is transferred on any clk edge where in_valid and
// in_ready are both high; in_ready depends only on FIFO fullness, never on
// in_valid or the assembler state, and the host may hold in_valid for as
// long as it likes.
module sample_pacer
  import audio_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        enable,
  input  logic [DIV_W-1:0]            div,
  output logic [15:0]                 o_digital,
  output logic                        sample_tick,
  output logic                        underrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
`ifdef SAMPLE_PACER_UNDERRUN_CNT_EN
  output logic [7:0]                  underrun_cnt,
`endif
  output asm_state_t                  dbg_asm_state
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  asm_state_t       state_q, state_d;
  sample_t          hold_q, hold_d;
  logic             accept;
  logic             push;
  logic             hold_load;
  frame_t           push_frame;
  frame_t           head_frame;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LW-1:0]    level;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             slot;
  logic             pop;
  frame_t           out_q, out_d;
  logic             tick_q, tick_d;
  logic             urun_q, urun_d;

  assign in_ready      = !fifo_full;
  assign accept        = in_valid && in_ready;
  assign dbg_asm_state = state_q;

  // Assembler state register; reset drops any half-received frame.
  always_ff @(posedge clk) begin
    if (rst) state_q <= HI;
    else     state_q <= state_d;
  end

  // Assembler next state: every accepted byte toggles between HI and LO.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (state_q == HI) state_d = LO;
      else               state_d = HI;
    end
  end

  // Assembler outputs: first byte is held, second byte completes the push.
  always_comb begin
    hold_load = 1'b0;
    push      = 1'b0;
    if (accept) begin
      if (state_q == HI) hold_load = 1'b1;
      else               push      = 1'b1;
    end
  end

  // Channel A byte holding register.
  always_comb begin
    hold_d = hold_load ? in_data : hold_q;
  end

  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end

  // Frame formed from the held channel A byte and the incoming channel B byte.
  always_comb begin
    push_frame.ch_a = hold_q;
    push_frame.ch_b = in_data;
  end

  sample_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .wdata_i(push_frame),
    .pop_i  (pop),
    .rdata_o(head_frame),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .level_o(level)
  );

  assign fifo_level = level;

  // Divider: paused counter tracks div; running counter fires a slot at zero
  // and reloads, so a new div only applies from the next reload.
  always_comb begin
    slot  = 1'b0;
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = div;
    end else if (cnt_q == '0) begin
      slot  = 1'b1;
      cnt_d = div;
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= div;
    else     cnt_q <= cnt_d;
  end

  // Slot handling: the FIFO state seen at the slot edge decides between a pop
  // and an underrun; a frame pushed in that same cycle is kept, not bypassed.
  always_comb begin
    pop    = slot && !fifo_empty;
    out_d  = pop ? head_frame : out_q;
    tick_d = slot;
    urun_d = slot && fifo_empty;
  end

  // Registered DAC word and slot pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '{ch_a: MIDSCALE, ch_b: MIDSCALE};
      tick_q <= 1'b0;
      urun_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      tick_q <= tick_d;
      urun_q <= urun_d;
    end
  end

  assign o_digital   = out_q;
  assign sample_tick = tick_q;
  assign underrun    = urun_q;

`ifdef SAMPLE_PACER_UNDERRUN_CNT_EN
  logic       en_q;
  logic [7:0] ucnt_q, ucnt_d;

  // Underrun count: restart on a pause-to-run edge, otherwise count pulses
  // up to saturation.
  always_comb begin
    ucnt_d = ucnt_q;
    if (enable && !en_q) begin
      ucnt_d = '0;
    end else if (urun_q && (ucnt_q != 8'hFF)) begin
      ucnt_d = ucnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q   <= 1'b0;
      ucnt_q <= '0;
    end else begin
      en_q   <= enable;
      ucnt_q <= ucnt_d;
    end
  end

  assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_sample_pacer.sv
// Self-checking bench for sample_pacer: hand-derived vector table, directed
// corner sequences, and randomized traffic against a frame-queue model.
module tb_sample_pacer;

  localparam int DEPTH = 8;
  localparam int DW    = 16;

  // ---------------- clock / DUT ----------------
  logic                      clk;
  logic                      rst;
  logic [7:0]                in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic                      enable;
  logic [DW-1:0]             div;
  logic [15:0]               o_digital;
  logic                      sample_tick;
  logic                      underrun;
  logic [$clog2(DEPTH):0]    fifo_level;
  audio_pkg::asm_state_t     dbg_state;
`ifdef SAMPLE_PACER_UNDERRUN_CNT_EN
  logic [7:0]                underrun_cnt;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sample_pacer #(
    .FIFO_DEPTH(DEPTH),
    .DIV_W     (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .enable       (enable),
    .div          (div),
    .o_digital    (o_digital),
    .sample_tick  (sample_tick),
    .underrun     (underrun),
    .fifo_level   (fifo_level),
`ifdef SAMPLE_PACER_UNDERRUN_CNT_EN
    .underrun_cnt (underrun_cnt),
`endif
    .dbg_asm_state(dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [15:0] exp_q[$];   // frames stored, oldest first
  bit          m_half;     // a channel-A byte is waiting for its partner
  logic [7:0]  m_byte;
  int          m_cnt;      // clocks left until the next slot
  logic [15:0] m_out;
  bit          m_tick;
  bit          m_urun;
  int          m_ucnt;
  bit          m_prev_en;

  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc_n, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_step();
    bit acc;
    bit slot;
    bit old_urun;
    if (rst) begin
      exp_q.delete();
      m_half    = 1'b0;
      m_byte    = '0;
      m_cnt     = int'(div);
      m_out     = 16'h8080;
      m_tick    = 1'b0;
      m_urun    = 1'b0;
      m_ucnt    = 0;
      m_prev_en = 1'b0;
    end else begin
      acc      = in_valid && (exp_q.size() < DEPTH);
      slot     = enable && (m_cnt == 0);
      old_urun = m_urun;
      m_tick   = slot;
      m_urun   = slot && (exp_q.size() == 0);
      if (slot && exp_q.size() > 0) m_out = exp_q.pop_front();
      if (acc) begin
        if (m_half) begin
          exp_q.push_back({m_byte, in_data});
          m_half = 1'b0;
        end else begin
          m_byte = in_data;
          m_half = 1'b1;
        end
      end
      if (!enable || m_cnt == 0) m_cnt = int'(div);
      else                       m_cnt = m_cnt - 1;
      if (enable && !m_prev_en)       m_ucnt = 0;
      else if (old_urun && m_ucnt < 255) m_ucnt = m_ucnt + 1;
      m_prev_en = enable;
    end
  endtask

  // One clock: model updates at the edge, DUT compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    cyc_n++;
    check("o_digital",   o_digital,   m_out);
    check("sample_tick", sample_tick, m_tick);
    check("underrun",    underrun,    m_urun);
    check("fifo_level",  fifo_level,  exp_q.size());
    check("in_ready",    in_ready,    exp_q.size() != DEPTH);
`ifdef SAMPLE_PACER_UNDERRUN_CNT_EN
    check("underrun_cnt", underrun_cnt, m_ucnt);
`endif
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit v, input logic [7:0] d, input bit e,
                       input logic [15:0] dv, input bit r);
    in_valid = v;
    in_data  = d;
    enable   = e;
    div      = dv;
    rst      = r;
    step();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          v;
    logic [7:0]  d;
    bit          en;
    bit          r;
    logic [15:0] x_dig;
    bit          x_tick;
    bit          x_urun;
    int          x_lvl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit v, logic [7:0] d, bit en, bit r,
                              logic [15:0] xd, bit xt, bit xu, int xl);
    vec_t t;
    t.v = v; t.d = d; t.en = en; t.r = r;
    t.x_dig = xd; t.x_tick = xt; t.x_urun = xu; t.x_lvl = xl;
    return t;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int got;
    logic [15:0] want;
    logic [7:0]  b0;
    logic [7:0]  b1;
    bit          r_v;
    bit          r_en;
    bit          r_rst;
    logic [15:0] r_div;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; enable = 1'b0; div = 16'd3;

    // Reset with enable high, then pacing at div=3 and draining to underrun.
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 8'h00, 1, 1, 16'h8080, 0, 0, 0));
    tbl.push_back(mk(1, 8'h11, 0, 0, 16'h8080, 0, 0, 0));
    tbl.push_back(mk(1, 8'h22, 0, 0, 16'h8080, 0, 0, 1));
    tbl.push_back(mk(1, 8'h33, 0, 0, 16'h8080, 0, 0, 1));
    tbl.push_back(mk(1, 8'h44, 0, 0, 16'h8080, 0, 0, 2));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 8'h00, 1, 0, 16'h8080, 0, 0, 2));
    tbl.push_back(mk(0, 8'h00, 1, 0, 16'h1122, 1, 0, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 8'h00, 1, 0, 16'h1122, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 16'h3344, 1, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 8'h00, 1, 0, 16'h3344, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 16'h3344, 1, 1, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 8'h00, 1, 0, 16'h3344, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 16'h3344, 1, 1, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].en, 16'd3, tbl[i].r);
      check($sformatf("tbl%0d_dig", i),  o_digital,   tbl[i].x_dig);
      check($sformatf("tbl%0d_tick", i), sample_tick, tbl[i].x_tick);
      check($sformatf("tbl%0d_urun", i), underrun,    tbl[i].x_urun);
      check($sformatf("tbl%0d_lvl", i),  fifo_level,  tbl[i].x_lvl);
      if (tbl[i].r) check($sformatf("tbl%0d_rdy", i), in_ready, 1);
    end

    // Full backpressure: 2*DEPTH bytes fill the FIFO, extra bytes bounce.
    drive(0, 8'h00, 0, 16'd1, 1);
    for (int i = 0; i < 2 * DEPTH + 2; i++) begin
      b0 = 8'h10 + 8'(i);
      drive(1, b0, 0, 16'd1, 0);
    end
    check("bp_level", fifo_level, DEPTH);
    check("bp_ready", in_ready, 0);
    got = 0;
    for (int c = 0; c < 100 && got < DEPTH; c++) begin
      drive(0, 8'h00, 1, 16'd1, 0);
      if (sample_tick && !underrun) begin
        b0 = 8'h10 + 8'(2 * got);
        b1 = 8'h11 + 8'(2 * got);
        want = {b0, b1};
        check("bp_order", o_digital, want);
        got++;
      end
    end
    check("bp_frames", got, DEPTH);

    // Long underrun stretch at div=0 (saturates the optional counter).
    for (int i = 0; i < 300; i++) drive(0, 8'h00, 1, 16'd0, 0);
    check("urun_stretch", underrun, 1);
`ifdef SAMPLE_PACER_UNDERRUN_CNT_EN
    check("ucnt_sat", underrun_cnt, 8'hFF);
`endif

    // Half-frame reset: AA must be discarded.
    drive(1, 8'hAA, 0, 16'd0, 0);
    check("half_state_lo", dbg_state, audio_pkg::LO);
    drive(0, 8'h00, 0, 16'd0, 1);
    check("half_state_hi", dbg_state, audio_pkg::HI);
    drive(1, 8'hBB, 0, 16'd0, 0);
    drive(1, 8'hCC, 0, 16'd0, 0);
    check("half_level", fifo_level, 1);
    drive(0, 8'h00, 1, 16'd0, 0);
    check("half_dig", o_digital, 16'hBBCC);
    check("half_tick", sample_tick, 1);

    // Simultaneous push and slot on an empty FIFO at div=0.
    drive(1, 8'h5A, 1, 16'd0, 0);
    drive(1, 8'hA5, 1, 16'd0, 0);
    check("sim_urun", underrun, 1);
    check("sim_level", fifo_level, 1);
    drive(0, 8'h00, 1, 16'd0, 0);
    check("sim_dig", o_digital, 16'h5AA5);
    check("sim_urun_clr", underrun, 0);
    check("sim_level0", fifo_level, 0);

    // Randomized traffic against the model.
    r_div = 16'd2;
    r_en  = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 5)  r_div = 16'($urandom_range(0, 4));
      if ($urandom_range(0, 99) < 3)  r_en  = ~r_en;
      r_rst = ($urandom_range(0, 299) == 0);
      r_v   = ($urandom_range(0, 99) < (i < 1000 ? 70 : 35));
      b0    = 8'($urandom_range(0, 255));
      drive(r_v, b0, r_en, r_div, r_rst);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc_n);
    $fatal(1, "watchdog expired");
  end

endmodule
